// File: rtl/guess_entry_buffer_pkg.sv
// rtl/guess_entry_buffer_pkg.sv - shared numberle definitions: blank digit code and entry FSM states
package guess_entry_buffer_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        SUBMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/guess_entry_buffer_btn_edge.sv
// rtl/guess_entry_buffer_btn_edge.sv - registered rising-edge pulse for one button level
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic prev;

    // History tracks the level even in reset, so a button held through reset is not an edge.
    always_ff @(posedge clock) begin
        prev <= btn;
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= btn & ~prev;
        end
    end

endmodule

// File: rtl/guess_entry_buffer.sv
// rtl/guess_entry_buffer.sv - keypad guess capture with cursor, backspace, submit handshake and try lockout
module guess_entry_buffer
    import guess_entry_buffer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MAX_TRIES  = 6,
    parameter logic [DIGIT_W-1:0] BLANK = DIGIT_W'(BLANK_DIGIT)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 DispVal,
    input  logic                               key_valid,
    input  logic                               btnR,
    input  logic                               btnL,
    input  logic                               btnC,
    input  logic                               game_over,
    input  logic                               guess_ready,
    output logic [NUM_DIGITS*DIGIT_W-1:0]      number,
    output logic [$clog2(NUM_DIGITS)-1:0]      digit,
    output logic [$clog2(MAX_TRIES+1)-1:0]     try,
    output logic                               guess_valid,
    output logic                               entry_err,
    output logic                               locked
);

    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [NUM_DIGITS*DIGIT_W-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [TRY_W-1:0] LAST_TRY   = TRY_W'(MAX_TRIES - 1);

    state_t                          state, state_n;
    logic [NUM_DIGITS*DIGIT_W-1:0]   number_n;
    logic [DIG_W-1:0]                digit_n;
    logic [TRY_W-1:0]                try_n;
    logic                            err_n;
    logic                            has_blank;
    logic                            ev_r, ev_l, ev_c;

    btn_edge u_edge_r (.clock(clock), .reset(reset), .btn(btnR), .pulse(ev_r));
    btn_edge u_edge_l (.clock(clock), .reset(reset), .btn(btnL), .pulse(ev_l));
    btn_edge u_edge_c (.clock(clock), .reset(reset), .btn(btnC), .pulse(ev_c));

    always_comb begin
        has_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (number[i*DIGIT_W +: DIGIT_W] == BLANK) begin
                has_blank = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ENTRY;
            number      <= ALL_BLANK;
            digit       <= '0;
            try         <= '0;
            guess_valid <= 1'b0;
            entry_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_n;
            number      <= number_n;
            digit       <= digit_n;
            try         <= try_n;
            guess_valid <= (state_n == SUBMIT);
            entry_err   <= err_n;
            locked      <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n  = state;
        number_n = number;
        digit_n  = digit;
        try_n    = try;
        err_n    = 1'b0;
        if (game_over) begin
            state_n = DONE;
        end else begin
            case (state)
                ENTRY: begin
                    if (ev_c) begin
                        if (has_blank) begin
                            err_n = 1'b1;
                        end else begin
                            state_n = SUBMIT;
                        end
                    end else if (ev_l) begin
                        number_n[digit*DIGIT_W +: DIGIT_W] = BLANK;
                        digit_n = (digit == '0) ? digit : digit - 1'b1;
                    end else if (ev_r) begin
                        digit_n = (digit == LAST_DIGIT) ? digit : digit + 1'b1;
                    end else if (key_valid && (DispVal <= DIGIT_W'(9) || DispVal == BLANK)) begin
                        number_n[digit*DIGIT_W +: DIGIT_W] = DispVal;
                    end
                end
                SUBMIT: begin
                    if (guess_valid && guess_ready) begin
                        try_n    = try + 1'b1;
                        number_n = ALL_BLANK;
                        digit_n  = '0;
                        state_n  = (try == LAST_TRY) ? DONE : ENTRY;
                    end
                end
                default: state_n = DONE;
            endcase
        end
    end

endmodule
